alu: RTL and testbench

//  32-bit integer ALU for the single-cycle/pipelined MIPS datapath (execute stage).

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_if.sv | 25 ++
 rtl/alu_core.sv | 53 +++++
 rtl/alu.sv | 56 +++++
 tb/tb_alu.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Execute-stage ALU bus: operands and op select in, registered result and flags out.
interface alu_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_e          f;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, a, b, f,
    input  y, zero, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, f,
    output y, zero, overflow, out_valid
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand inversion, shared adder, logic ops,
// set-less-than compares and signed overflow detect.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);

  localparam int MSB = WIDTH - 1;

  logic             subtract;
  logic [WIDTH-1:0] bMux;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
  logic             addOvf;
  logic             sltBit;

  // SLTU also routes through the subtracting adder so its borrow comes from one carry chain.
  always_comb begin
    subtract          = op_i[2] | (op_i[1:0] == 2'b11);
    bMux              = subtract ? ~b_i : b_i;
    {carryOut, sum}   = {1'b0, a_i} + {1'b0, bMux} + {{WIDTH{1'b0}}, subtract};
    addOvf            = (a_i[MSB] == bMux[MSB]) && (sum[MSB] != a_i[MSB]);
    sltBit            = sum[MSB] ^ addOvf;
  end

  always_comb begin
    y_o   = '0;
    ovf_o = 1'b0;
    case (op_i)
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_ADD:  begin
        y_o   = sum;
        ovf_o = addOvf;
      end
      ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, ~carryOut};
      ALU_ANDN: y_o = a_i & ~b_i;
      ALU_ORN:  y_o = a_i | ~b_i;
      ALU_SUB:  begin
        y_o   = sum;
        ovf_o = addOvf;
      end
      ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, sltBit};
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered execute-stage ALU: one-cycle latency, result/flags hold while idle.
module alu import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] coreY;
  logic             coreOvf;
  logic [WIDTH-1:0] y_d, y_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .op_i  (bus.f),
    .y_o   (coreY),
    .ovf_o (coreOvf)
  );

  // Zero is derived from the incoming result so it is registered alongside Y.
  always_comb begin
    y_d    = y_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (bus.in_valid) begin
      y_d    = coreY;
      zero_d = (coreY == '0);
      ovf_d  = coreOvf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      valid_q <= bus.in_valid;
    end
  end

  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed corner vectors plus random ops against an arithmetic model.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        o;
    int          issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  exp_t        sbq[$];
  logic [31:0] heldY = '0;
  logic        heldZ = 1'b1;
  logic        heldO = 1'b0;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference written from the arithmetic meaning of each op, using 64-bit signed math.
  function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] y, output logic o);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    o = 1'b0;
    y = '0;
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: begin
        r = sa + sb;
        y = a + b;
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd3: y = (a < b) ? 32'd1 : 32'd0;
      3'd4: y = a & ~b;
      3'd5: y = a | ~b;
      3'd6: begin
        r = sa - sb;
        y = a - b;
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      default: y = (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ey;
    logic        eo;
    @(negedge clk);
    bus.in_valid = valid;
    bus.a        = a;
    bus.b        = b;
    bus.f        = alu_op_e'(op);
    if (valid) begin
      refModel(op, a, b, ey, eo);
      sbq.push_back('{y: ey, z: (ey == 32'd0), o: eo, issue: cyc});
    end
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h7FFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      4: v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: pops on out_valid, otherwise verifies the outputs hold their last value.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("latency", 32'(cyc), 32'(e.issue + 1));
          checkOutput("Y", bus.y, e.y);
          checkOutput("zero", 32'(bus.zero), 32'(e.z));
          checkOutput("overflow", 32'(bus.overflow), 32'(e.o));
          heldY = e.y;
          heldZ = e.z;
          heldO = e.o;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].issue + 1 <= cyc) begin
          checkOutput("missing out_valid", 32'(bus.out_valid), 32'd1);
          void'(sbq.pop_front());
        end
        checkOutput("hold Y", bus.y, heldY);
        checkOutput("hold zero", 32'(bus.zero), 32'(heldZ));
        checkOutput("hold overflow", 32'(bus.overflow), 32'(heldO));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " Y"}, bus.y, 32'd0);
    checkOutput({tag, " zero"}, 32'(bus.zero), 32'd1);
    checkOutput({tag, " overflow"}, 32'(bus.overflow), 32'd0);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.f        = ALU_AND;

    #1 rst = 1'b1;
    #1 checkResetValues("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int f = 0; f < 8; f++) applyStimulus(1'b1, 3'(f), 32'h1111_1111, 32'h8888_8888);
    applyStimulus(1'b1, 3'd2, 32'h7FFF_FFFF, 32'h0000_0001);
    applyStimulus(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus(1'b1, 3'd6, 32'h1234_5678, 32'h1234_5678);
    applyStimulus(1'b1, 3'd7, 32'h8000_0000, 32'h0000_0001);
    applyStimulus(1'b1, 3'd3, 32'h8000_0000, 32'h0000_0001);
    applyStimulus(1'b1, 3'd6, 32'h8000_0000, 32'h0000_0001);
    applyStimulus(1'b1, 3'd7, 32'h7FFF_FFFF, 32'h8000_0000);

    applyStimulus(1'b1, 3'd2, 32'h0000_0005, 32'h0000_0003);
    applyStimulus(1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0000_0000);
    applyStimulus(1'b1, 3'd1, 32'h0000_00F0, 32'h0000_000F);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), pickOperand(), pickOperand());
    end

    // Reset lands between issuing an op and its capturing edge, so that op is dropped.
    applyStimulus(1'b1, 3'd1, 32'hFFFF_0000, 32'h0000_FFFF);
    #2 rst = 1'b1;
    sbq.delete();
    heldY = '0;
    heldZ = 1'b1;
    heldO = 1'b0;
    #1 checkResetValues("mid reset");
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), pickOperand(), pickOperand());
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
